// File: rtl/vram_arb_pkg.sv
// Shared types and default sizes for the two-requester VRAM port arbiter.
// VRAM_CLEAR_EN adds the post-reset clear state.
package vram_arb_pkg;

    localparam int ADDR_W_DEF     = 11;
    localparam int DATA_W_DEF     = 8;
    localparam int STARVE_MAX_DEF = 4;

`ifdef VRAM_CLEAR_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_CLEAR   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/vram_port_arb.sv
// Arbitrates a CPU (r0) and a video/DMA (r1) requester onto one registered RAM port; VRAM_CLEAR_EN zero-fills the RAM after reset.
// Latency: request in cycle 0 with the FSM idle -> ack and rdata in cycle 3; at most one access per 3 cycles.
// Backpressure: requesters hold req and fields until ack; r0 has priority unless r1 has lost STARVE_MAX times in a row.
module vram_port_arb
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    localparam int              SC_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

`ifdef VRAM_CLEAR_EN
    localparam state_t RST_ST = ST_CLEAR;
    logic [ADDR_W-1:0] clr_addr;
`else
    localparam state_t RST_ST = ST_IDLE;
`endif

    state_t          state, state_nx;
    logic [SC_W-1:0] starve;
    logic            sel;
    logic            r0_pend, r1_pend;
    logic            gnt0, gnt1;

    // A requester is not eligible in its own ack cycle: its req is still the old one.
    assign r0_pend = r0_req & ~r0_ack;
    assign r1_pend = r1_req & ~r1_ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RST_ST;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        case (state)
            ST_IDLE: begin
                gnt1 = r1_pend & (~r0_pend | (starve == SC_MAX));
                gnt0 = r0_pend & ~gnt1;
                if (gnt0 | gnt1) state_nx = ST_ISSUE;
            end
            ST_ISSUE:   state_nx = ST_CAPTURE;
            ST_CAPTURE: state_nx = ST_IDLE;
`ifdef VRAM_CLEAR_EN
            ST_CLEAR:   if (clr_addr == '1) state_nx = ST_IDLE;
`endif
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            r0_ack    <= 1'b0;
            r1_ack    <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            starve    <= '0;
            sel       <= 1'b0;
        end else begin
            ram_en <= 1'b0;
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            if (gnt0 | gnt1) begin
                ram_en    <= 1'b1;
                sel       <= gnt1;
                ram_we    <= gnt1 ? r1_we    : r0_we;
                ram_addr  <= gnt1 ? r1_addr  : r0_addr;
                ram_wdata <= gnt1 ? r1_wdata : r0_wdata;
            end
            if (gnt1)
                starve <= '0;
            else if (gnt0 && r1_pend && starve != SC_MAX)
                starve <= starve + SC_W'(1);
            // ram_q now holds the word sampled at the end of ISSUE.
            if (state == ST_CAPTURE) begin
                if (sel) begin
                    r1_rdata <= ram_q;
                    r1_ack   <= 1'b1;
                end else begin
                    r0_rdata <= ram_q;
                    r0_ack   <= 1'b1;
                end
            end
`ifdef VRAM_CLEAR_EN
            if (state == ST_CLEAR) begin
                ram_en    <= 1'b1;
                ram_we    <= 1'b1;
                ram_addr  <= clr_addr;
                ram_wdata <= '0;
            end
`endif
        end
    end

`ifdef VRAM_CLEAR_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clr_addr <= '0;
            busy     <= 1'b0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + ADDR_W'(1);
            busy     <= 1'b1;
        end else begin
            busy     <= 1'b0;
        end
    end
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_vram_port_arb.sv
// Bench for vram_port_arb: transaction-level timing/arbitration model plus directed literal checks.
module tb_vram_port_arb;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int SMAX  = 4;
    localparam int DEPTH = 1 << AW;
`ifdef VRAM_CLEAR_EN
    localparam int CLR_CYC = DEPTH;
`else
    localparam int CLR_CYC = 0;
`endif

    logic          clock, reset_n;
    logic          r0_req, r0_we, r1_req, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_ack, r1_ack;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          ram_en, ram_we, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_q = '0;

    vram_port_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clock(clock), .reset_n(reset_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_q(ram_q), .busy(busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous RAM, read-during-write returns old data.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clock) begin
        if (ram_en) begin
            ram_q <= ram[ram_addr];
            if (ram_we) ram[ram_addr] <= ram_wdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: each access occupies the port for 3 cycles from its grant.
    logic [DW-1:0]      mdl_mem [DEPTH];
    int                 free_at, issue_at, starve, clr_start, clr_end;
    int                 ack_at [2];
    logic [DW-1:0]      pend_rd [2];
    logic [DW-1:0]      exp_rd [2];
    logic [AW+DW:0]     exp_cmd;

    always @(negedge clock) begin
        if (!reset_n) begin
            check("reset_outputs", {ram_en, ram_we, ram_addr, ram_wdata, r0_ack, r1_ack,
                                    r0_rdata, r1_rdata, busy}, '0);
            ack_at[0] = -1; ack_at[1] = -1;
            exp_rd[0] = '0; exp_rd[1] = '0;
            issue_at  = -1;
            starve    = 0;
            clr_start = cyc + 1;
            clr_end   = cyc + 1 + CLR_CYC;
            free_at   = clr_end;
            if (CLR_CYC > 0)
                for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        end else begin
            bit busy_exp, p0, p1;
            for (int r = 0; r < 2; r++)
                if (cyc == ack_at[r]) exp_rd[r] = pend_rd[r];
            busy_exp = (cyc > clr_start) && (cyc <= clr_end);
            check("r0_ack", r0_ack, cyc == ack_at[0]);
            check("r1_ack", r1_ack, cyc == ack_at[1]);
            check("r0_rdata", r0_rdata, exp_rd[0]);
            check("r1_rdata", r1_rdata, exp_rd[1]);
            check("busy", busy, busy_exp);
            check("ram_en", ram_en, busy_exp || (cyc == issue_at));
            if (cyc == issue_at) check("ram_cmd", {ram_we, ram_addr, ram_wdata}, exp_cmd);
            if (cyc >= free_at) begin
                p0 = r0_req && (cyc != ack_at[0]);
                p1 = r1_req && (cyc != ack_at[1]);
                if (p0 || p1) begin
                    int            w;
                    logic          we;
                    logic [AW-1:0] a;
                    logic [DW-1:0] d;
                    w  = (p1 && (!p0 || starve == SMAX)) ? 1 : 0;
                    we = w ? r1_we : r0_we;
                    a  = w ? r1_addr : r0_addr;
                    d  = w ? r1_wdata : r0_wdata;
                    pend_rd[w] = mdl_mem[a];
                    if (we) mdl_mem[a] = d;
                    exp_cmd   = {we, a, d};
                    issue_at  = cyc + 1;
                    ack_at[w] = cyc + 3;
                    free_at   = cyc + 3;
                    if (w == 1) starve = 0;
                    else if (p1 && starve < SMAX) starve++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit who, input bit rq, input bit we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (who) begin
            r1_req = rq; r1_we = we; r1_addr = a; r1_wdata = d;
        end else begin
            r0_req = rq; r0_we = we; r0_addr = a; r0_wdata = d;
        end
    endtask

    task automatic access(input bit who, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd);
        int t0;
        t0  = cyc;
        lat = -1;
        rd  = '0;
        drive(who, 1'b1, we, a, d);
        for (int i = 0; i < CLR_CYC + 40; i++) begin
            tick();
            if (who ? r1_ack : r0_ack) begin
                lat = cyc - t0;
                rd  = who ? r1_rdata : r0_rdata;
                break;
            end
        end
        drive(who, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic new_req(input bit who);
        logic [AW-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                        : AW'($urandom_range(0, 15));
        drive(who, 1'b1, 1'($urandom_range(0, 1)), a, DW'($urandom));
    endtask

    initial begin
        int            lat, lat0, lat1, t0, nb;
        logic [DW-1:0] rd, rd0, rd1;
        bit            d0, d1;

        reset_n = 1'b0;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = (CLR_CYC > 0) ? 8'hFF : DW'(i * 7 + 3);
            mdl_mem[i] = ram[i];
        end
        repeat (3) tick();
        reset_n = 1'b1;

        nb = 0;
        for (int i = 0; i < CLR_CYC + 4; i++) begin
            tick();
            if (busy) nb++;
        end
        check("clear_busy_cycles", nb, CLR_CYC);

        // Write then read back; the write returns the pre-write word.
        access(0, 1, 11'h123, 8'hA5, lat, rd);
        check("wr_latency", lat, 3);
        check("wr_old_data", rd, (CLR_CYC > 0) ? 8'h00 : 8'hF8);
        access(0, 0, 11'h123, 8'h00, lat, rd);
        check("rd_latency", lat, 3);
        check("rd_data", rd, 8'hA5);

        // Simultaneous requests: r0 first, r1 three cycles later.
        t0 = cyc; lat0 = -1; lat1 = -1; rd0 = '0; rd1 = '0;
        drive(0, 1, 0, 11'h041, 8'h00);
        drive(1, 1, 1, 11'h040, 8'h66);
        for (int i = 0; i < 20 && (lat0 < 0 || lat1 < 0); i++) begin
            tick();
            if (r0_ack) begin lat0 = cyc - t0; rd0 = r0_rdata; drive(0, 0, 0, '0, '0); end
            if (r1_ack) begin lat1 = cyc - t0; rd1 = r1_rdata; drive(1, 0, 0, '0, '0); end
        end
        check("both_r0_latency", lat0, 3);
        check("both_r1_latency", lat1, 6);
        check("both_r0_rdata", rd0, (CLR_CYC > 0) ? 8'h00 : 8'hCA);
        check("both_r1_rdata", rd1, (CLR_CYC > 0) ? 8'h00 : 8'hC3);
        tick();

        // Top address is distinct from address 0.
        access(0, 1, 11'h000, 8'h11, lat, rd);
        access(1, 1, 11'h7FF, 8'h5A, lat, rd);
        check("top_wr_latency", lat, 3);
        access(0, 0, 11'h7FF, 8'h00, lat, rd);
        check("top_rd_data", rd, 8'h5A);
        access(0, 0, 11'h000, 8'h00, lat, rd);
        check("no_wrap_data", rd, 8'h11);

        // Reset during ISSUE of an r1 read aborts it; r1 is then served again.
        access(1, 1, 11'h055, 8'h3C, lat, rd);
        drive(1, 1, 0, 11'h055, 8'h00);
        tick();
        reset_n = 1'b0;
        #1;
        check("abort_outputs", {ram_en, ram_we, ram_addr, ram_wdata, r0_ack, r1_ack,
                                r0_rdata, r1_rdata, busy}, '0);
        repeat (2) tick();
        reset_n = 1'b1;
        t0 = cyc; lat = -1; rd = '0;
        for (int i = 0; i < CLR_CYC + 40; i++) begin
            tick();
            if (r1_ack) begin lat = cyc - t0; rd = r1_rdata; break; end
        end
        drive(1, 0, 0, '0, '0);
        check("rearb_latency", lat, CLR_CYC + 3);
        check("rearb_rdata", rd, (CLR_CYC > 0) ? 8'h00 : 8'h3C);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            d0 = r0_req && r0_ack;
            d1 = r1_req && r1_ack;
            if (d0) begin
                if ($urandom_range(0, 1) == 1) new_req(0); else drive(0, 0, 0, '0, '0);
            end else if (!r0_req && $urandom_range(0, 9) < 4) new_req(0);
            if (d1) begin
                if ($urandom_range(0, 1) == 1) new_req(1); else drive(1, 0, 0, '0, '0);
            end else if (!r1_req && $urandom_range(0, 9) < 4) new_req(1);
            tick();
        end
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_port_arb.md
VRAM_PORT_ARB -- requirements
Module: vram_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive losses by requester 1 before it is forced to win.
REQ-004 SHALL have port clock  in  1  single clock; all logic posedge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports r0_req, r0_we  in  1, 1  CPU access request and write flag.
REQ-007 SHALL have ports r0_addr, r0_wdata  in  ADDR_W, DATA_W  CPU access address and write data.
REQ-008 SHALL have ports r0_ack, r0_rdata  out  1, DATA_W  CPU completion pulse and read data.
REQ-009 SHALL have ports r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata, mirroring REQ-006..008 for the video/DMA requester.
REQ-010 SHALL have ports ram_en, ram_we, ram_addr, ram_wdata  out  1, 1, ADDR_W, DATA_W  one RAM port, all registered.
REQ-011 SHALL have port ram_q  in  DATA_W  RAM read data, valid one clock after the RAM samples ram_en.
REQ-012 SHALL have port busy  out  1  high while the clear sequence runs.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, CAPTURE, CLEAR.
REQ-014 IDLE: SHALL grant a pending request by registering its we/addr/wdata onto the ram_* outputs with ram_en=1, then enter ISSUE.
REQ-015 ISSUE: SHALL hold ram_en=1 for exactly this one cycle, then enter CAPTURE with ram_en=0.
REQ-016 CAPTURE: SHALL register ram_q into the granted rX_rdata, set rX_ack for one cycle, and return to IDLE.
REQ-017 Latency: for a request high at cycle 0 with the FSM in IDLE, ack SHALL be high in cycle 3; maximum throughput SHALL be one access per 3 cycles.
REQ-018 Writes SHALL follow the same timing; rdata SHALL then carry the pre-write RAM contents (read-during-write old data).
REQ-019 rX_rdata SHALL hold its value until that requester's next ack.
REQ-020 Handshake: requester SHALL hold req and its fields stable until ack; the arbiter SHALL ignore rX_req in the cycle rX_ack is high.
REQ-021 Priority: r0 SHALL win when both requests are pending, unless the starve counter equals STARVE_MAX, in which case r1 SHALL win.
REQ-022 The starve counter SHALL increment when r1 is pending and r0 is granted, SHALL clear when r1 is granted, and SHALL saturate at STARVE_MAX.
REQ-023 A request arriving during ISSUE or CAPTURE SHALL wait and be arbitrated in the next IDLE.
REQ-024 Requests SHALL never be dropped; both acks SHALL never be high in the same cycle.

Reset
REQ-025 reset_n low SHALL asynchronously clear ram_en, ram_we, ram_addr, ram_wdata, r0_ack, r1_ack, r0_rdata, r1_rdata, the starve counter and busy to 0.
REQ-026 Reset SHALL force the FSM to IDLE, or to CLEAR when VRAM_CLEAR_EN is defined.
REQ-027 Reset during ISSUE or CAPTURE SHALL abort the access with no ack; the requester re-arbitrates after release.

Configuration
REQ-028 With macro VRAM_CLEAR_EN defined: after reset, CLEAR SHALL write 0 to addresses 0..2^ADDR_W-1, one per cycle, with busy=1 and no grants; it SHALL then enter IDLE and drop busy.
REQ-029 Without VRAM_CLEAR_EN: the CLEAR state and its address counter SHALL be absent, and busy SHALL be tied to 0.

Structure
REQ-030 Package vram_arb_pkg SHALL hold the FSM state enum and the default values of ADDR_W, DATA_W and STARVE_MAX.
REQ-031 The block SHALL be a single module with no sub-module; the starve counter and clear counter stay inline.

Verification
REQ-032 Write r0 addr 0x123 data 0xA5, then read r0 0x123 -> second ack in cycle 3 after req, r0_rdata=0xA5.
REQ-033 r0 and r1 request in the same cycle -> r0 acked first, r1 acked 3 cycles later.
REQ-034 r0 requests continuously and r1 is pending -> r1 granted after exactly 4 r0 grants, counter back to 0.
REQ-035 VRAM_CLEAR_EN defined, preload 0xFF, reset -> busy high 2048 cycles, then any read returns 0x00.
REQ-036 Assert reset_n low in ISSUE of an r1 read -> no r1_ack, all outputs 0, request served normally after release.
REQ-037 r1 write to 0x7FF then r0 read of 0x7FF -> r0_rdata equals the r1 data, and the address does not wrap.
